mandel_sched: RTL and testbench

Row scheduler and framebuffer-write arbiter for a multi-core Mandelbrot renderer. It takes one frame request (`x_start`, `y_start`, `step`) from the view-parameter logic and deals framebuffer rows one at a time to `NCORE` row-render cores. It computes each row's imaginary coordinate incrementally and merges the cores' pixel writes onto the single framebuffer write port with round-robin arbitration. It sits between the top-level parameter FSM and the `bitmap_addr`/`bram_sdp` write path.

---
 rtl/mandel_pkg.sv | 40 ++++
 rtl/mandel_sched_rr_arbiter.sv | 42 ++++
 rtl/mandel_sched.sv | 169 ++++++++++++++++
 tb/tb_mandel_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot row scheduler: coordinate format,
// scheduler state encoding and the rotating/fixed-priority pick used for dispatch and arbitration.
package mandel_pkg;

    localparam int FP_WIDTH = 25;
    localparam int FP_INT   = 3;
    localparam int MAXCORE  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping within n entries; ptr=0 gives lowest-set-bit.
    function automatic pick_t rr_pick(input logic [MAXCORE-1:0] req,
                                      input logic [2:0] ptr,
                                      input int unsigned n);
        pick_t      res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned k = 0; k < MAXCORE; k++) begin
            idx = 3'((32'(ptr) + k) % n);
            if ((k < n) && !res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mandel_sched_rr_arbiter.sv
// Round-robin arbiter over NCORE requesters: one-hot grant from the current
// pointer, pointer moves past the winner on every grant and holds otherwise.
module rr_arbiter #(
    parameter int NCORE = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NCORE-1:0] req_i,
    output logic [NCORE-1:0] gnt_o
);
    import mandel_pkg::*;

    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [MAXCORE-1:0] req_ext_s;
    pick_t              pick_s;

    // Grant selection and pointer advance
    always_comb begin
        req_ext_s              = '0;
        req_ext_s[NCORE-1:0]   = req_i;
        pick_s                 = rr_pick(req_ext_s, 3'(ptr_q), 32'(NCORE));
        if (pick_s.found) begin
            gnt_o = NCORE'(1) << pick_s.idx;
            ptr_d = (pick_s.idx == 3'(NCORE - 1)) ? '0 : IW'(pick_s.idx + 3'd1);
        end else begin
            gnt_o = '0;
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mandel_sched.sv
// Frame row scheduler: deals rows to render cores with incremental imaginary
// coordinate and merges core pixel writes onto one registered framebuffer port.
module mandel_sched #(
    parameter int CORDW     = 16,
    parameter int FP_WIDTH  = mandel_pkg::FP_WIDTH,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int NCORE     = 4,
    parameter int CIDXW     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic signed [FP_WIDTH-1:0] x_start_i,
    input  logic signed [FP_WIDTH-1:0] y_start_i,
    input  logic signed [FP_WIDTH-1:0] step_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NCORE-1:0]           core_start_o,
    output logic signed [FP_WIDTH-1:0] core_x0_o,
    output logic signed [FP_WIDTH-1:0] core_yc_o,
    output logic signed [FP_WIDTH-1:0] core_step_o,
    input  logic [NCORE-1:0]           core_busy_i,
    input  logic [NCORE-1:0]           core_req_i,
    input  logic [NCORE*CORDW-1:0]     core_x_i,
    input  logic [NCORE*CIDXW-1:0]     core_cidx_i,
    output logic [NCORE-1:0]           core_gnt_o,
    output logic                       fb_we_o,
    output logic [CORDW-1:0]           fb_x_o,
    output logic [CORDW-1:0]           fb_y_o,
    output logic [CIDXW-1:0]           fb_cidx_o
);
    import mandel_pkg::*;

    // Row registers are sized for the larger screen dimension.
    localparam int RW = $clog2(((FB_HEIGHT > FB_WIDTH) ? FB_HEIGHT : FB_WIDTH) + 1);

    sched_state_t               state_q, state_d;
    logic [RW-1:0]              row_q, row_d;
    logic signed [FP_WIDTH-1:0] yacc_q, yacc_d, x0_q, x0_d, step_q, step_d;
    logic [NCORE-1:0]           launched_q, launched_d;
    logic [RW-1:0]              core_row_q [NCORE];
    logic [RW-1:0]              core_row_d [NCORE];
    logic                       fb_we_q, fb_we_d;
    logic [CORDW-1:0]           fb_x_q, fb_x_d, fb_y_q, fb_y_d;
    logic [CIDXW-1:0]           fb_cidx_q, fb_cidx_d;
    logic [NCORE-1:0]           free_s, dispatch_s, gnt_s;
    logic [MAXCORE-1:0]         free_ext_s;
    pick_t                      free_pick_s;
    logic                       rows_left_s, issue_s;

    rr_arbiter #(.NCORE(NCORE)) u_arb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (core_req_i),
        .gnt_o   (gnt_s)
    );

    // Launched guard covers the start-to-busy latency of a core.
    assign free_s = ~core_busy_i & ~launched_q;

    // Dispatch decision: lowest-index free core, one per cycle
    always_comb begin
        free_ext_s            = '0;
        free_ext_s[NCORE-1:0] = free_s;
        free_pick_s           = rr_pick(free_ext_s, 3'd0, 32'(NCORE));
        rows_left_s           = (row_q != RW'(FB_HEIGHT));
        issue_s               = (state_q == ST_DISPATCH) && rows_left_s && free_pick_s.found;
        dispatch_s            = issue_s ? (NCORE'(1) << free_pick_s.idx) : '0;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = start_i ? ST_DISPATCH : ST_IDLE;
            ST_DISPATCH: state_d = rows_left_s ? ST_DISPATCH : ST_DRAIN;
            ST_DRAIN:    state_d = ((&free_s) && !(|core_req_i)) ? ST_DONE : ST_DRAIN;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: frame parameters, row walk, launch guard, write merge
    always_comb begin
        x0_d   = x0_q;
        step_d = step_q;
        row_d  = row_q;
        yacc_d = yacc_q;
        if ((state_q == ST_IDLE) && start_i) begin
            x0_d   = x_start_i;
            step_d = step_i;
            row_d  = '0;
            yacc_d = y_start_i;
        end else if (issue_s) begin
            row_d  = row_q + RW'(1);
            yacc_d = yacc_q + step_q;
        end else begin
            row_d  = row_q;
        end
        launched_d = (launched_q & ~core_busy_i) | dispatch_s;
        fb_we_d    = |gnt_s;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_cidx_d  = fb_cidx_q;
        for (int i = 0; i < NCORE; i++) begin
            core_row_d[i] = dispatch_s[i] ? row_q : core_row_q[i];
            fb_x_d        = gnt_s[i] ? core_x_i[i*CORDW +: CORDW] : fb_x_d;
            fb_y_d        = gnt_s[i] ? CORDW'(core_row_q[i]) : fb_y_d;
            fb_cidx_d     = gnt_s[i] ? core_cidx_i[i*CIDXW +: CIDXW] : fb_cidx_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x0_q       <= '0;
            step_q     <= '0;
            row_q      <= '0;
            yacc_q     <= '0;
            launched_q <= '0;
            fb_we_q    <= 1'b0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_cidx_q  <= '0;
            for (int i = 0; i < NCORE; i++) begin
                core_row_q[i] <= '0;
            end
        end else begin
            x0_q       <= x0_d;
            step_q     <= step_d;
            row_q      <= row_d;
            yacc_q     <= yacc_d;
            launched_q <= launched_d;
            fb_we_q    <= fb_we_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_cidx_q  <= fb_cidx_d;
            for (int i = 0; i < NCORE; i++) begin
                core_row_q[i] <= core_row_d[i];
            end
        end
    end

    // Outputs
    always_comb begin
        busy_o       = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
        done_o       = (state_q == ST_DONE);
        core_start_o = dispatch_s;
        core_x0_o    = x0_q;
        core_yc_o    = yacc_q;
        core_step_o  = step_q;
        core_gnt_o   = gnt_s;
        fb_we_o      = fb_we_q;
        fb_x_o       = fb_x_q;
        fb_y_o       = fb_y_q;
        fb_cidx_o    = fb_cidx_q;
    end

endmodule

// File: tb/tb_mandel_sched.sv
// Directed bench for mandel_sched: a 1-core/4-row instance for coordinate stepping
// and a 4-core/180-row instance for dispatch, arbitration, ignored start and reset.
module tb_mandel_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: NCORE=1, FB_HEIGHT=4 ----------------
    logic               a_start;
    logic signed [24:0] a_xs, a_ys, a_stp, a_x0, a_yc, a_cstep;
    logic               a_busy, a_done, a_fbwe;
    logic [0:0]         a_cstart, a_cbusy, a_gnt;
    logic [15:0]        a_fbx, a_fby;
    logic [7:0]         a_fbc;
    int                 a_cnt;

    mandel_sched #(.NCORE(1), .FB_HEIGHT(4)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(a_start),
        .x_start_i(a_xs), .y_start_i(a_ys), .step_i(a_stp),
        .busy_o(a_busy), .done_o(a_done), .core_start_o(a_cstart),
        .core_x0_o(a_x0), .core_yc_o(a_yc), .core_step_o(a_cstep),
        .core_busy_i(a_cbusy), .core_req_i(1'b0), .core_x_i(16'd0), .core_cidx_i(8'd0),
        .core_gnt_o(a_gnt), .fb_we_o(a_fbwe), .fb_x_o(a_fbx), .fb_y_o(a_fby), .fb_cidx_o(a_fbc)
    );

    always @(posedge clk) begin
        if (!rst_n) a_cnt <= 0;
        else if (a_cstart[0]) a_cnt <= 10;
        else if (a_cnt != 0) a_cnt <= a_cnt - 1;
    end
    assign a_cbusy[0] = (a_cnt != 0);

    logic signed [24:0] a_seen [4];
    int   a_nst = 0, a_ndone = 0;
    logic a_busy_at_done = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_cstart[0]) begin
                if (a_nst < 4) a_seen[a_nst] = a_yc;
                a_nst++;
            end
            if (a_done) begin
                a_ndone++;
                a_busy_at_done = a_cbusy[0];
            end
        end
    end

    // ---------------- instance B: NCORE=4, FB_HEIGHT=180 ----------------
    logic               b_start;
    logic signed [24:0] b_xs, b_ys, b_stp, b_x0, b_yc, b_cstep;
    logic               b_busy, b_done, b_fbwe;
    logic [3:0]         b_cstart, b_cbusy, b_req, b_gnt, b_pend;
    logic [63:0]        b_cx;
    logic [31:0]        b_cc;
    logic [15:0]        b_fbx, b_fby;
    logic [7:0]         b_fbc;
    int                 b_cnt [4];
    int                 b_lb = 60;

    mandel_sched u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start),
        .x_start_i(b_xs), .y_start_i(b_ys), .step_i(b_stp),
        .busy_o(b_busy), .done_o(b_done), .core_start_o(b_cstart),
        .core_x0_o(b_x0), .core_yc_o(b_yc), .core_step_o(b_cstep),
        .core_busy_i(b_cbusy), .core_req_i(b_req), .core_x_i(b_cx), .core_cidx_i(b_cc),
        .core_gnt_o(b_gnt), .fb_we_o(b_fbwe), .fb_x_o(b_fbx), .fb_y_o(b_fby), .fb_cidx_o(b_fbc)
    );

    // Stub cores: busy rises two edges after core_start, lasts b_lb cycles
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                b_pend[i] <= 1'b0;
                b_cnt[i]  <= 0;
            end else begin
                b_pend[i] <= b_cstart[i];
                if (b_pend[i]) b_cnt[i] <= b_lb;
                else if (b_cnt[i] != 0) b_cnt[i] <= b_cnt[i] - 1;
            end
        end
    end
    always_comb begin
        b_cbusy = '0;
        for (int i = 0; i < 4; i++) b_cbusy[i] = (b_cnt[i] != 0);
    end

    logic [3:0]         b_prev_start = '0;
    logic signed [24:0] b_y0 = '0, b_st = '0, b_yexp = '0;
    int                 b_nst = 0, b_ndone = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev_start = '0;
        end else begin
            if (b_start && !b_busy && !b_done) begin
                b_nst   = 0;
                b_ndone = 0;
                b_y0    = b_ys;
                b_st    = b_stp;
                b_yexp  = b_ys;
            end
            for (int i = 0; i < 4; i++) begin
                if (b_cstart[i]) check_eq("no_double_dispatch", {63'd0, b_prev_start[i] | b_cbusy[i]}, 64'd0);
            end
            if (|b_cstart) begin
                check_eq("core_yc", b_yc, b_yexp);
                check_eq("start_onehot", 64'($countones(b_cstart)), 64'd1);
                b_yexp = b_yexp + b_st;
                b_nst++;
            end
            if (b_done) b_ndone++;
            b_prev_start = b_cstart;
        end
    end

    logic signed [24:0] a_exp [4];
    int k;

    initial begin
        a_exp[0] = -25'sd6291456; a_exp[1] = -25'sd6225920;
        a_exp[2] = -25'sd6160384; a_exp[3] = -25'sd6094848;
        a_start = 1'b0; a_xs = -25'sd8388608; a_ys = -25'sd6291456; a_stp = 25'sd65536;
        b_start = 1'b0; b_xs = -25'sd8388608; b_ys = -25'sd6291456; b_stp = 25'sd32768;
        b_req = 4'b0000;
        b_cx  = {16'd103, 16'd102, 16'd101, 16'd100};
        b_cc  = {8'd13, 8'd12, 8'd11, 8'd10};
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {63'd0, b_busy}, 64'd0);
        check_eq("rst_done", {63'd0, b_done}, 64'd0);
        check_eq("rst_fb_we", {63'd0, b_fbwe}, 64'd0);
        check_eq("rst_core_start", {60'd0, b_cstart}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-core frame: four rows stepped by 1/64 from -1.5
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_eq("a_busy_rise", {63'd0, a_busy}, 64'd1);
        check_eq("a_first_start", {63'd0, a_cstart[0]}, 64'd1);
        k = 0;
        while (!a_done && k < 300) begin @(negedge clk); k++; end
        check_eq("a_done_seen", {63'd0, a_done}, 64'd1);
        check_eq("a_busy_at_done", {63'd0, a_busy}, 64'd0);
        repeat (3) @(negedge clk);
        check_eq("a_nstart", 64'(a_nst), 64'd4);
        check_eq("a_ndone", 64'(a_ndone), 64'd1);
        check_eq("a_core_busy_at_done", {63'd0, a_busy_at_done}, 64'd0);
        for (int i = 0; i < 4; i++) check_eq("a_core_yc", a_seen[i], a_exp[i]);
        check_eq("a_core_x0", a_x0, a_xs);
        check_eq("a_core_step", a_cstep, a_stp);

        // Four-core frame, cores held busy long so rows 0..3 sit on cores 0..3
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("b_first_rows", 64'(b_nst), 64'd4);

        b_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            check_eq("rr_all_gnt", {60'd0, b_gnt}, 64'(4'b0001 << (j % 4)));
            @(negedge clk);
            check_eq("rr_all_we", {63'd0, b_fbwe}, 64'd1);
            check_eq("rr_all_y", {48'd0, b_fby}, 64'(j % 4));
            check_eq("rr_all_x", {48'd0, b_fbx}, 64'(100 + (j % 4)));
            check_eq("rr_all_cidx", {56'd0, b_fbc}, 64'(10 + (j % 4)));
        end
        b_req = 4'b0100;
        #1 check_eq("rr_c2_gnt", {60'd0, b_gnt}, 64'd4);
        @(negedge clk);
        check_eq("rr_c2_y", {48'd0, b_fby}, 64'd2);
        b_req = 4'b1001;
        #1 check_eq("rr_c3_gnt", {60'd0, b_gnt}, 64'd8);
        @(negedge clk);
        check_eq("rr_c3_y", {48'd0, b_fby}, 64'd3);
        b_req = 4'b0001;
        #1 check_eq("rr_c0_gnt", {60'd0, b_gnt}, 64'd1);
        @(negedge clk);
        check_eq("rr_c0_y", {48'd0, b_fby}, 64'd0);
        b_req = 4'b0000;
        @(negedge clk);
        check_eq("rr_idle_we", {63'd0, b_fbwe}, 64'd0);

        // Mid-frame start with new parameters must be ignored
        b_lb = 3;
        b_xs = 25'sd123; b_ys = 25'sd456; b_stp = 25'sd7;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (!b_done && k < 3000) begin @(negedge clk); k++; end
        check_eq("b_done_seen", {63'd0, b_done}, 64'd1);
        repeat (3) @(negedge clk);
        check_eq("b_nstart", 64'(b_nst), 64'd180);
        check_eq("b_ndone", 64'(b_ndone), 64'd1);
        check_eq("b_x0_kept", b_x0, -25'sd8388608);
        check_eq("b_step_kept", b_cstep, 25'sd32768);

        // Reset near row 90, then a clean full frame
        b_xs = 25'sd0; b_ys = -25'sd4194304; b_stp = 25'sd23302;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (b_nst < 90 && k < 1000) begin @(negedge clk); k++; end
        check_eq("b_reached_row90", {63'd0, b_nst >= 90}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", {63'd0, b_busy}, 64'd0);
        check_eq("mid_rst_done", {63'd0, b_done}, 64'd0);
        check_eq("mid_rst_start", {60'd0, b_cstart}, 64'd0);
        check_eq("mid_rst_we", {63'd0, b_fbwe}, 64'd0);
        check_eq("mid_rst_x", {48'd0, b_fbx}, 64'd0);
        check_eq("mid_rst_y", {48'd0, b_fby}, 64'd0);
        check_eq("mid_rst_cidx", {56'd0, b_fbc}, 64'd0);
        check_eq("mid_rst_no_done", 64'(b_ndone), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (!b_done && k < 3000) begin @(negedge clk); k++; end
        check_eq("b2_done_seen", {63'd0, b_done}, 64'd1);
        repeat (3) @(negedge clk);
        check_eq("b2_nstart", 64'(b_nst), 64'd180);
        check_eq("b2_ndone", 64'(b_ndone), 64'd1);

        // Pointer restarts at core 0 after reset
        b_req = 4'b1001;
        #1 check_eq("rr_ptr_reset", {60'd0, b_gnt}, 64'd1);
        @(negedge clk);
        b_req = 4'b0000;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
